// File: rtl/logic_sweep_driver_if.sv
// -----------------------------------------------------------------------------
// Module      : logic_sweep_driver_if
// Description : Bundle of control, status and mux-facing signals of the
//               logic sweep driver.
//               slave  : the sweep driver itself
//                        (takes start/abort/mux_in, drives everything else)
//               master : the controller / mux side (the reverse directions)
// Ports (signals):
//   start, abort          control into the driver
//   mux_in                output of the mux under test
//   x_out, y_out, sel_out vector driven onto the mux
//   busy, done            sweep status
//   result, err_mask      8-bit capture and mismatch tables
//   error                 OR of err_mask
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface logic_sweep_driver_if;
    logic       start;
    logic       abort;
    logic       mux_in;
    logic       x_out;
    logic       y_out;
    logic       sel_out;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] err_mask;
    logic       error;

    modport slave (
        input  start, abort, mux_in,
        output x_out, y_out, sel_out, busy, done, result, err_mask, error
    );

    modport master (
        output start, abort, mux_in,
        input  x_out, y_out, sel_out, busy, done, result, err_mask, error
    );
endinterface

`default_nettype wire

// File: rtl/logic_sweep_driver.sv
// -----------------------------------------------------------------------------
// Module      : logic_sweep_driver
// Description : On-chip self-test stimulus/capture stage for the and/or
//               selector mux. Walks {sel,x,y} through 0..7, holds each vector
//               SETTLE cycles, samples the mux output and compares it against
//               out = sel ? (x & y) : (x | y).
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    logic_sweep_driver_if.slave
//          start/abort/mux_in in; x_out/y_out/sel_out/busy/done/result/
//          err_mask/error out
// Parameters:
//   SETTLE  cycles each vector is held before sampling (1..15)
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module logic_sweep_driver #(
    parameter int SETTLE = 1
) (
    input  wire                    clk,
    input  wire                    rst_n,
    logic_sweep_driver_if.slave    bus
);

    localparam logic [3:0] c_settle = 4'(SETTLE);
    localparam logic [2:0] c_last   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     state_q,    state_d;
    logic [2:0] idx_q,      idx_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic [7:0] result_q,   result_d;
    logic [7:0] err_mask_q, err_mask_d;

    logic       w_expected;

    // Reference mux function for vector i = {sel,x,y}.
    function automatic logic exp_bit(input logic [2:0] i);
        return i[2] ? (i[1] & i[0]) : (i[1] | i[0]);
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        err_mask_d = err_mask_q;
        w_expected = exp_bit(idx_q);

        case (state_q)
            ST_IDLE: begin
                // abort has priority over start
                if (bus.start && !bus.abort) begin
                    idx_d      = 3'd0;
                    result_d   = 8'h00;
                    err_mask_d = 8'h00;
                    busy_d     = 1'b1;
                    wait_cnt_d = c_settle;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q <= 4'd1) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                // An aborted SAMPLE cycle leaves the tables untouched.
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    result_d[idx_q]   = bus.mux_in;
                    // Case inequality so an X/Z on the mux output is flagged.
                    err_mask_d[idx_q] = (bus.mux_in !== w_expected);
                    if (idx_q != c_last) begin
                        idx_d      = idx_q + 3'd1;
                        wait_cnt_d = c_settle;
                        state_d    = ST_WAIT;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            wait_cnt_q <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 8'h00;
            err_mask_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            err_mask_q <= err_mask_d;
        end
    end

    // The vector index is the driven vector: {sel,x,y} == idx.
    assign bus.sel_out  = idx_q[2];
    assign bus.x_out    = idx_q[1];
    assign bus.y_out    = idx_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.err_mask = err_mask_q;
    assign bus.error    = |err_mask_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_sweep_driver.sv
// -----------------------------------------------------------------------------
// Module      : tb_logic_sweep_driver
// Description : Directed self-checking bench for logic_sweep_driver.
//               Two instances: SETTLE=1 with a selectable mux model, and
//               SETTLE=3 with a golden mux.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_logic_sweep_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;   // 0 golden, 1 stuck0, 2 stuck1, 3 swapped select

    always #5 clk = ~clk;

    logic_sweep_driver_if bus1 ();
    logic_sweep_driver_if bus2 ();

    logic_sweep_driver #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    logic_sweep_driver #(.SETTLE(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    always_comb begin
        case (mode)
            0:       bus1.mux_in = bus1.sel_out ? (bus1.x_out & bus1.y_out) : (bus1.x_out | bus1.y_out);
            1:       bus1.mux_in = 1'b0;
            2:       bus1.mux_in = 1'b1;
            default: bus1.mux_in = bus1.sel_out ? (bus1.x_out | bus1.y_out) : (bus1.x_out & bus1.y_out);
        endcase
    end
    assign bus2.mux_in = bus2.sel_out ? (bus2.x_out & bus2.y_out) : (bus2.x_out | bus2.y_out);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on DUT1 (sampled at edge 0), then observe k edges later.
    // rs/ab: edge at which a start/abort is sampled (0 = none).
    // lat: edge count at which done was first seen, -1 if never.
    // busy_ab: busy observed right after the abort edge.
    task automatic sweep1(input int rs, input int ab, input int bound,
                          output int lat, output logic busy_ab);
        lat     = -1;
        busy_ab = 1'bx;
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.abort = 1'b0;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            bus1.start = (k == rs - 1);
            bus1.abort = (k == ab - 1);
            if (k == ab) busy_ab = bus1.busy;
            if (bus1.done && lat < 0) lat = k;
            if (lat >= 0) break;
        end
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
    endtask

    initial begin
        int   lat;
        logic bab;
        int   vec_bad;

        bus1.start = 1'b0; bus1.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0;

        // Reset state
        #12;
        check("rst_busy",   32'(bus1.busy), 32'd0);
        check("rst_done",   32'(bus1.done), 32'd0);
        check("rst_result", 32'(bus1.result), 32'h00);
        check("rst_err",    32'(bus1.err_mask), 32'h00);
        check("rst_vec",    32'({bus1.sel_out, bus1.x_out, bus1.y_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // start and abort together in IDLE: abort wins
        bus1.start = 1'b1; bus1.abort = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0; bus1.abort = 1'b0;
        check("start_abort_idle_busy", 32'(bus1.busy), 32'd0);

        // T1 golden mux
        mode = 0;
        sweep1(0, 0, 200, lat, bab);
        check("t1_latency", 32'(lat), 32'd16);
        check("t1_result",  32'(bus1.result), 32'h8E);
        check("t1_err",     32'(bus1.err_mask), 32'h00);
        check("t1_error",   32'(bus1.error), 32'd0);
        check("t1_busy_in_done", 32'(bus1.busy), 32'd0);
        check("t1_last_vec", 32'({bus1.sel_out, bus1.x_out, bus1.y_out}), 32'd7);
        bus1.start = 1'b1;   // start during DONE is ignored
        @(negedge clk);
        bus1.start = 1'b0;
        check("t1_done_one_cycle", 32'(bus1.done), 32'd0);
        check("t1_start_in_done_ignored", 32'(bus1.busy), 32'd0);

        // T2 stuck-at mux outputs
        mode = 1;
        sweep1(0, 0, 200, lat, bab);
        check("t2_s0_result", 32'(bus1.result), 32'h00);
        check("t2_s0_err",    32'(bus1.err_mask), 32'h8E);
        check("t2_s0_error",  32'(bus1.error), 32'd1);
        mode = 2;
        sweep1(0, 0, 200, lat, bab);
        check("t2_s1_result", 32'(bus1.result), 32'hFF);
        check("t2_s1_err",    32'(bus1.err_mask), 32'h71);

        // T3 swapped select
        mode = 3;
        sweep1(0, 0, 200, lat, bab);
        check("t3_result", 32'(bus1.result), 32'hE8);
        check("t3_err",    32'(bus1.err_mask), 32'h66);
        check("t3_error",  32'(bus1.error), 32'd1);

        // T4 restart ignored while busy; abort mid-sweep
        mode = 0;
        sweep1(5, 0, 200, lat, bab);
        check("t4_restart_latency", 32'(lat), 32'd16);
        check("t4_restart_result",  32'(bus1.result), 32'h8E);
        mode = 2;
        sweep1(0, 5, 40, lat, bab);
        check("t4_abort_busy",   32'(bab), 32'd0);
        check("t4_abort_nodone", 32'(lat), 32'hFFFF_FFFF);
        check("t4_abort_result", 32'(bus1.result), 32'h03);
        check("t4_abort_err",    32'(bus1.err_mask), 32'h01);

        // T5 asynchronous reset mid-WAIT
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_pre_busy", 32'(bus1.busy), 32'd1);
        check("t5_pre_vec",  32'({bus1.sel_out, bus1.x_out, bus1.y_out}), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",   32'(bus1.busy), 32'd0);
        check("t5_rst_vec",    32'({bus1.sel_out, bus1.x_out, bus1.y_out}), 32'd0);
        check("t5_rst_result", 32'(bus1.result), 32'h00);
        check("t5_rst_err",    32'(bus1.err_mask), 32'h00);
        check("t5_rst_error",  32'(bus1.error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        sweep1(0, 0, 200, lat, bab);
        check("t5_post_latency", 32'(lat), 32'd16);
        check("t5_post_result",  32'(bus1.result), 32'h8E);

        // T6 SETTLE=3: vector k/4 at k edges after start, done at 32
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        lat     = -1;
        vec_bad = 0;
        for (int k = 0; k <= 200; k++) begin
            if (k > 0) @(negedge clk);
            if (bus2.done) begin
                lat = k;
                break;
            end
            if (k < 32 && {bus2.sel_out, bus2.x_out, bus2.y_out} != 3'(k / 4)) vec_bad++;
        end
        check("t6_latency", 32'(lat), 32'd32);
        check("t6_vec_hold_errors", 32'(vec_bad), 32'd0);
        check("t6_result", 32'(bus2.result), 32'h8E);
        check("t6_err",    32'(bus2.err_mask), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
